// File: rtl/trigger_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_pkg: ring-buffer widths and state encoding shared by capture blocks.
// Rev 1.0
// ---------------------------------------------------------------------------
package trigger_pkg;

  localparam int C_DATA_WIDTH     = 16;
  localparam int C_BUF_ADDR_WIDTH = 10;
  localparam int C_LEN_WIDTH      = 16;
  localparam int C_FIFO_DEPTH     = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/trigger_window_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_window_reader_if: control, BRAM read port and AXI-Stream bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
interface trigger_window_reader_if
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH     = C_DATA_WIDTH,
  parameter int BUF_ADDR_WIDTH = C_BUF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = C_LEN_WIDTH
) ();

  logic                      start;
  logic [BUF_ADDR_WIDTH-1:0] trigger_offset;
  logic [LEN_WIDTH-1:0]      pre_trigger;
  logic [LEN_WIDTH-1:0]      window_len;
  logic                      bram_en;
  logic [BUF_ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0]     bram_rdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_WIDTH-1:0]     m_axis_tdata;
  logic                      m_axis_tlast;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, trigger_offset, pre_trigger, window_len, bram_rdata, m_axis_tready,
    output bram_en, bram_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done
  );

  modport slave (
    output start, trigger_offset, pre_trigger, window_len, bram_rdata, m_axis_tready,
    input  bram_en, bram_addr, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/axis_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_skid_fifo: small output FIFO; head is combinational, push+pop legal when full.
// Rev 1.0
// ---------------------------------------------------------------------------
module axis_skid_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rstn,
  input  wire logic                   push_i,
  input  wire logic [WIDTH-1:0]       din_i,
  input  wire logic                   pop_i,
  output logic      [WIDTH-1:0]       head_o,
  output logic      [$clog2(DEPTH):0] count_o,
  output logic                        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Storage carries no reset; only the pointers and occupancy define emptiness.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/trigger_window_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trigger_window_reader: streams window_len ring samples from (trigger - pre) on AXI-Stream.
// Rev 1.0
// ---------------------------------------------------------------------------
module trigger_window_reader
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH     = C_DATA_WIDTH,
  parameter int BUF_ADDR_WIDTH = C_BUF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = C_LEN_WIDTH,
  parameter int FIFO_DEPTH     = C_FIFO_DEPTH
) (
  input wire logic                clk,
  input wire logic                rstn,
  trigger_window_reader_if.master bus
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      issued_q, issued_d;
  logic [LEN_WIDTH-1:0]      emitted_q, emitted_d;
  logic [BUF_ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                      pending_q;
  logic                      done_q, done_d;

  logic [CNT_W-1:0]          fifo_count;
  logic [DATA_WIDTH-1:0]     fifo_head;
  logic                      fifo_empty;
  logic [CNT_W:0]            credit_used;
  logic                      issue;
  logic                      pop;
  logic                      tlast;
  logic                      last_beat;

  // In-flight reads count against FIFO space so a returning word always has a slot.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pending_q};
  assign issue       = (state_q == RUN) && (issued_q < len_q) && (credit_used < DEPTH_LIM);
  assign pop         = !fifo_empty && bus.m_axis_tready;

  // tlast is derived at the output from the emitted count, so the FIFO holds data only.
  assign tlast     = !fifo_empty && (emitted_q == (len_q - LEN_ONE));
  assign last_beat = pop && tlast;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    emitted_d   = emitted_q;
    read_addr_d = read_addr_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.window_len != '0) begin
            len_d       = bus.window_len;
            issued_d    = '0;
            emitted_d   = '0;
            read_addr_d = bus.trigger_offset - bus.pre_trigger[BUF_ADDR_WIDTH-1:0];
            state_d     = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          read_addr_d = read_addr_q + BUF_ADDR_WIDTH'(1);
          issued_d    = issued_q + LEN_ONE;
        end
        if (pop) begin
          emitted_d = emitted_q + LEN_ONE;
        end
        if (last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      emitted_q   <= '0;
      read_addr_q <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      emitted_q   <= emitted_d;
      read_addr_q <= read_addr_d;
      pending_q   <= issue;
      done_q      <= done_d;
    end
  end

  axis_skid_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (pending_q),
    .din_i   (bus.bram_rdata),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign bus.bram_en       = issue;
  assign bus.bram_addr     = read_addr_q;
  assign bus.m_axis_tvalid = !fifo_empty;
  assign bus.m_axis_tdata  = fifo_empty ? '0 : fifo_head;
  assign bus.m_axis_tlast  = tlast;
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = done_q;

endmodule
`default_nettype wire
